feedback_tx: RTL
================

FEEDBACK_TX -- requirements
Module: feedback_tx

Interface
REQ-001 Parameter: WORD_WIDTH, default 16, width of every ID/energy/Q-value field.
REQ-002 Parameter: MAX_NEIGHBORS, default 32, neighbor table depth; rd_addr width is log2(MAX_NEIGHBORS).
REQ-003 Parameter: PKT_FEEDBACK, default 3'd2, packetType code driven on every emitted packet.
REQ-004 Reset and clock: one clock; reset is asynchronous and active-high.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 en  in  1  start request, sampled in S_IDLE only.
REQ-008 myNodeID, myClusterID, myEnergy  in  WORD_WIDTH each  local node fields.
REQ-009 neighborCount  in  WORD_WIDTH  valid table entries.
REQ-010 rd_en  out  1  neighbor table read strobe.
REQ-011 rd_addr  out  log2(MAX_NEIGHBORS)  table entry index.
REQ-012 mSourceID, mClusterID, mEnergyLeft, mQValue  in  WORD_WIDTH each  table read data, valid the cycle after rd_en.
REQ-013 pkt_valid  out  1  outgoing feedback packet valid.
REQ-014 pkt_ready  in  1  downstream accepts packet.
REQ-015 fSourceID, fClusterID, fEnergyLeft, fQValue  out  WORD_WIDTH each  packet fields.
REQ-016 packetType  out  3  packet type.
REQ-017 bestHopID  out  WORD_WIDTH  mSourceID of max-Q neighbor.
REQ-018 busy  out  1  high whenever state is not S_IDLE.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 States S_IDLE, S_CHK, S_READ, S_CMP, S_SEND, S_DONE; one transition per rising edge.
REQ-021 S_IDLE with en=1: latch my* inputs and clamped count (min(neighborCount, MAX_NEIGHBORS)), clear index n, maxQ=0, bestHopID=all-ones, found=0; go S_CHK.
REQ-022 S_IDLE with en=0: remain; en outside S_IDLE is ignored.
REQ-023 S_CHK: n==count -> S_SEND; else -> S_READ.
REQ-024 S_READ: rd_en=1, rd_addr=n; -> S_CMP; rd_en is 0 in every other state.
REQ-025 S_CMP: if found==0 or mQValue > maxQ (unsigned, strict), load maxQ=mQValue, bestHopID=mSourceID, found=1; n=n+1; -> S_CHK.
REQ-026 Ties keep the lowest-index entry; mClusterID and mEnergyLeft are not used.
REQ-027 S_SEND: pkt_valid=1; fSourceID=myNodeID, fClusterID=myClusterID, fEnergyLeft=myEnergy, fQValue=maxQ, packetType=PKT_FEEDBACK, all latched values.
REQ-028 Packet fields and pkt_valid stay stable until pkt_ready=1 at a rising edge; then -> S_DONE.
REQ-029 S_DONE: done=1 for exactly one cycle, pkt_valid=0; -> S_IDLE.
REQ-030 Latency with pkt_ready held high: en sampled at edge 0, pkt_valid high after edge 3N+1, done high after edge 3N+2, S_IDLE after edge 3N+3 (N = clamped count).
REQ-031 N=0: no reads; fQValue=0, bestHopID=all-ones.
REQ-032 neighborCount > MAX_NEIGHBORS: scan entries 0..MAX_NEIGHBORS-1 only; rd_addr never wraps.
REQ-033 neighborCount change during a scan has no effect; the latched count is used.

Reset
REQ-034 rst=1 forces, asynchronously, state=S_IDLE and all outputs 0 except bestHopID = all-ones; n, maxQ, found cleared.
REQ-035 Reset mid-scan or mid-S_SEND aborts the packet; no pkt_valid or done follows until a new en.

Verification
REQ-036 N=3, entries (ID,Q)=(5,10),(7,40),(9,25), pkt_ready=1 -> pkt_valid after edge 10, fQValue=40, bestHopID=7, packetType=2, done after edge 11.
REQ-037 N=0 -> pkt_valid after edge 1, fQValue=0, bestHopID=16'hFFFF, no rd_en pulses.
REQ-038 N=2, (4,30),(6,30) -> bestHopID=4, fQValue=30.
REQ-039 pkt_ready low 5 cycles during S_SEND -> fields stable, done only after the edge where pkt_ready=1; en pulsed while busy is ignored.
REQ-040 rst asserted during second S_CMP of N=3 scan -> outputs to reset values immediately, no packet; a later en runs a full correct scan.
REQ-041 neighborCount=40 -> exactly 32 rd_en pulses, rd_addr 0..31, pkt_valid after edge 97.

Source files
------------

// File: rtl/feedback_tx.sv
// Feedback packet transmitter: scans the neighbor table for the highest Q-value entry,
// then emits one feedback packet carrying the local node fields and that best Q-value.
module feedback_tx #(
  parameter int         WORD_WIDTH    = 16,
  parameter int         MAX_NEIGHBORS = 32,
  parameter logic [2:0] PKT_FEEDBACK  = 3'd2
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             en,
  input  logic [WORD_WIDTH-1:0]            myNodeID,
  input  logic [WORD_WIDTH-1:0]            myClusterID,
  input  logic [WORD_WIDTH-1:0]            myEnergy,
  input  logic [WORD_WIDTH-1:0]            neighborCount,
  output logic                             rd_en,
  output logic [$clog2(MAX_NEIGHBORS)-1:0] rd_addr,
  input  logic [WORD_WIDTH-1:0]            mSourceID,
  input  logic [WORD_WIDTH-1:0]            mClusterID,
  input  logic [WORD_WIDTH-1:0]            mEnergyLeft,
  input  logic [WORD_WIDTH-1:0]            mQValue,
  output logic                             pkt_valid,
  input  logic                             pkt_ready,
  output logic [WORD_WIDTH-1:0]            fSourceID,
  output logic [WORD_WIDTH-1:0]            fClusterID,
  output logic [WORD_WIDTH-1:0]            fEnergyLeft,
  output logic [WORD_WIDTH-1:0]            fQValue,
  output logic [2:0]                       packetType,
  output logic [WORD_WIDTH-1:0]            bestHopID,
  output logic                             busy,
  output logic                             done
);

  localparam int AW = $clog2(MAX_NEIGHBORS);
  // One extra bit so the index can reach MAX_NEIGHBORS itself, which ends the scan.
  localparam int CW = $clog2(MAX_NEIGHBORS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_READ,
    S_CMP,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_WIDTH-1:0] maxQ_q, maxQ_d;
  logic [WORD_WIDTH-1:0] bestHop_q, bestHop_d;
  logic                  found_q, found_d;
  logic [WORD_WIDTH-1:0] myNode_q, myNode_d;
  logic [WORD_WIDTH-1:0] myCluster_q, myCluster_d;
  logic [WORD_WIDTH-1:0] myEnergy_q, myEnergy_d;
  logic [CW-1:0]         clampedCount;
  logic                  unusedTableBits;

  assign unusedTableBits = ^{mClusterID, mEnergyLeft};

  always_comb begin
    if (neighborCount > WORD_WIDTH'(MAX_NEIGHBORS)) clampedCount = CW'(MAX_NEIGHBORS);
    else                                            clampedCount = neighborCount[CW-1:0];
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      count_q     <= '0;
      maxQ_q      <= '0;
      bestHop_q   <= '1;
      found_q     <= 1'b0;
      myNode_q    <= '0;
      myCluster_q <= '0;
      myEnergy_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      count_q     <= count_d;
      maxQ_q      <= maxQ_d;
      bestHop_q   <= bestHop_d;
      found_q     <= found_d;
      myNode_q    <= myNode_d;
      myCluster_q <= myCluster_d;
      myEnergy_q  <= myEnergy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    count_d     = count_q;
    maxQ_d      = maxQ_q;
    bestHop_d   = bestHop_q;
    found_d     = found_q;
    myNode_d    = myNode_q;
    myCluster_d = myCluster_q;
    myEnergy_d  = myEnergy_q;
    rd_en       = 1'b0;
    pkt_valid   = 1'b0;
    done        = 1'b0;
    packetType  = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          myNode_d    = myNodeID;
          myCluster_d = myClusterID;
          myEnergy_d  = myEnergy;
          count_d     = clampedCount;
          n_d         = '0;
          maxQ_d      = '0;
          bestHop_d   = '1;
          found_d     = 1'b0;
          state_d     = S_CHK;
        end
      end
      S_CHK: state_d = (n_q == count_q) ? S_SEND : S_READ;
      S_READ: begin
        rd_en   = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        // Strict compare keeps the lowest-index entry on ties.
        if (!found_q || (mQValue > maxQ_q)) begin
          maxQ_d    = mQValue;
          bestHop_d = mSourceID;
          found_d   = 1'b1;
        end
        n_d     = n_q + CW'(1);
        state_d = S_CHK;
      end
      S_SEND: begin
        pkt_valid  = 1'b1;
        packetType = PKT_FEEDBACK;
        if (pkt_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr     = n_q[AW-1:0];
  assign busy        = (state_q != S_IDLE);
  assign fSourceID   = myNode_q;
  assign fClusterID  = myCluster_q;
  assign fEnergyLeft = myEnergy_q;
  assign fQValue     = maxQ_q;
  assign bestHopID   = bestHop_q;

endmodule
